// File: rtl/seq_checker.sv
// Self-synchronising checker for the recurrence x[n] = x[n-2] + x[n-3] (mod 2^W).
// Define SEQ_CHK_CAPTURE_EN to keep the first-mismatch capture registers (bad_word/bad_exp).
module seq_checker #(
    parameter int unsigned W      = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_en,
    input  logic [W-1:0]     seq_in,
    output logic             locked,
    output logic             mis,
    output logic             err,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     bad_word,
    output logic [W-1:0]     bad_exp
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [7:0]       LOCK_N_C = 8'(LOCK_N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t       state_q;
    logic [W-1:0] h0_q, h1_q, h2_q;
    logic [1:0]   fcnt_q;
    logic [7:0]   rcnt_q;
    logic [W-1:0] exp_d;
    logic         match_d;
    logic         lock_mis_d;

    assign exp_d      = h1_q + h2_q;
    assign match_d    = (seq_in == exp_d);
    assign lock_mis_d = in_en && !clr && (state_q == LOCK) && !match_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            h0_q    <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
            locked  <= 1'b0;
            mis     <= 1'b0;
            err     <= 1'b0;
            chk_cnt <= '0;
            err_cnt <= '0;
        end else begin
            mis <= 1'b0;
            if (clr) begin
                state_q <= FILL;
                h0_q    <= '0;
                h1_q    <= '0;
                h2_q    <= '0;
                fcnt_q  <= '0;
                rcnt_q  <= '0;
                locked  <= 1'b0;
                err     <= 1'b0;
                chk_cnt <= '0;
                err_cnt <= '0;
            end else if (in_en) begin
                h2_q <= h1_q;
                h1_q <= h0_q;
                h0_q <= seq_in;
                case (state_q)
                    FILL: begin
                        fcnt_q <= fcnt_q + 2'd1;
                        if (fcnt_q == 2'd2) state_q <= ACQ;
                    end
                    ACQ: begin
                        if (match_d) begin
                            rcnt_q <= rcnt_q + 8'd1;
                            if (rcnt_q + 8'd1 == LOCK_N_C) begin
                                state_q <= LOCK;
                                locked  <= 1'b1;
                            end
                        end else begin
                            rcnt_q <= '0;
                        end
                    end
                    LOCK: begin
                        if (chk_cnt != '1) chk_cnt <= chk_cnt + CNT_ONE;
                        if (!match_d) begin
                            if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
                            mis     <= 1'b1;
                            err     <= 1'b1;
                            rcnt_q  <= '0;
                            state_q <= ACQ;
                            locked  <= 1'b0;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

`ifdef SEQ_CHK_CAPTURE_EN
    // err is still low on the first LOCK mismatch since reset/clr, so it gates the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_word <= '0;
            bad_exp  <= '0;
        end else if (clr) begin
            bad_word <= '0;
            bad_exp  <= '0;
        end else if (lock_mis_d && !err) begin
            bad_word <= seq_in;
            bad_exp  <= exp_d;
        end
    end
`else
    assign bad_word = '0;
    assign bad_exp  = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Randomised self-checking bench for seq_checker (default and CNT_W=4 instances on one stimulus).
// The reference model keeps the accepted samples in a queue and applies the recurrence rules directly.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst, clr, in_en;
    logic [31:0] seq_in;

    logic        locked, mis, err;
    logic [15:0] chk_cnt, err_cnt;
    logic [31:0] bad_word, bad_exp;

    logic        locked4, mis4, err4;
    logic [3:0]  chk_cnt4, err_cnt4;
    logic [31:0] bad_word4, bad_exp4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    seq_checker #(.W(32), .CNT_W(16), .LOCK_N(4)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_en(in_en), .seq_in(seq_in),
        .locked(locked), .mis(mis), .err(err), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
        .bad_word(bad_word), .bad_exp(bad_exp)
    );

    seq_checker #(.W(32), .CNT_W(4), .LOCK_N(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr), .in_en(in_en), .seq_in(seq_in),
        .locked(locked4), .mis(mis4), .err(err4), .chk_cnt(chk_cnt4), .err_cnt(err_cnt4),
        .bad_word(bad_word4), .bad_exp(bad_exp4)
    );

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int unsigned m_run, m_chk, m_errs;
    bit          m_lock, m_mis, m_err;
    logic [31:0] m_bw, m_be;

    function automatic void model_reset();
        mq.delete();
        m_run = 0; m_chk = 0; m_errs = 0;
        m_lock = 0; m_mis = 0; m_err = 0;
        m_bw = '0; m_be = '0;
    endfunction

    function automatic void model_step(input bit en, input bit cl, input logic [31:0] x);
        logic [31:0] e;
        int unsigned n;
        m_mis = 0;
        if (cl) begin
            model_reset();
        end else if (en) begin
            n = mq.size();
            if (n >= 3) begin
                e = mq[n-2] + mq[n-3];
                if (!m_lock) begin
                    if (x == e) begin
                        m_run++;
                        if (m_run == 4) m_lock = 1;
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    m_chk++;
                    if (x != e) begin
                        m_errs++;
                        m_mis = 1;
                        if (!m_err) begin
                            m_bw = x;
                            m_be = e;
                        end
                        m_err = 1;
                        m_lock = 0;
                        m_run = 0;
                    end
                end
            end
            mq.push_back(x);
            if (mq.size() > 3) void'(mq.pop_front());
        end
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] ebw, ebe;
`ifdef SEQ_CHK_CAPTURE_EN
        ebw = m_bw; ebe = m_be;
`else
        ebw = '0; ebe = '0;
`endif
        check("locked",   locked,   m_lock);
        check("mis",      mis,      m_mis);
        check("err",      err,      m_err);
        check("chk_cnt",  chk_cnt,  sat(m_chk, 65535));
        check("err_cnt",  err_cnt,  sat(m_errs, 65535));
        check("bad_word", bad_word, ebw);
        check("bad_exp",  bad_exp,  ebe);
        check("locked4",  locked4,  m_lock);
        check("mis4",     mis4,     m_mis);
        check("chk_cnt4", chk_cnt4, sat(m_chk, 15));
        check("err_cnt4", err_cnt4, sat(m_errs, 15));
    endtask

    // ---------------- generator model ----------------
    logic [31:0] g0, g1, g2;

    function automatic logic [31:0] gen_next();
        logic [31:0] w;
        w  = g1 + g2;
        g2 = g1;
        g1 = g0;
        g0 = w;
        return w;
    endfunction

    task automatic send(input bit en, input bit cl, input logic [31:0] x);
        in_en  = en;
        clr    = cl;
        seq_in = x;
        @(posedge clk);
        model_step(en, cl, x);
        #1;
        compare_all();
    endtask

    task automatic restart();
        send(1'b1, 1'b1, $urandom);
        send(1'b1, 1'b0, 32'd0);
        send(1'b1, 1'b0, 32'd1);
        send(1'b1, 1'b0, 32'd1);
        g2 = 32'd0; g1 = 32'd1; g0 = 32'd1;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; clr = 1'b0; in_en = 1'b0; seq_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Nominal stream 0,1,1,1,2,2,3 -> lock on the 7th accepted sample.
        send(1'b1, 1'b0, 32'd0);
        send(1'b1, 1'b0, 32'd1);
        send(1'b1, 1'b0, 32'd1);
        g2 = 32'd0; g1 = 32'd1; g0 = 32'd1;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, gen_next());
        check("lock_after_7", locked, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, gen_next());
        check("chk_cnt_4", chk_cnt, 16'd4);
        // Replace 12 with 13 after history 5,7,9.
        w = gen_next();
        check("gen_is_12", w, 32'd12);
        send(1'b1, 1'b0, 32'd13);
        check("mis_13", mis, 1'b1);
        check("locked_drop", locked, 1'b0);
        for (int i = 0; i < 12; i++) send(1'b1, 1'b0, gen_next());
        check("relocked", locked, 1'b1);
        check("err_sticky", err, 1'b1);

        // Wrap-around: history FFFFFFFF, 2, 5 expects 1.
        send(1'b1, 1'b1, $urandom);
        send(1'b1, 1'b0, 32'hFFFF_FFFF);
        send(1'b1, 1'b0, 32'h0000_0002);
        send(1'b1, 1'b0, 32'h0000_0005);
        send(1'b1, 1'b0, 32'h0000_0001);
        check("wrap_no_mis", mis, 1'b0);
        g2 = 32'd2; g1 = 32'd5; g0 = 32'd1;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, gen_next());
        check("wrap_lock", locked, 1'b1);

        // clr together with in_en while locked.
        send(1'b1, 1'b1, gen_next());
        check("clr_locked", locked, 1'b0);
        check("clr_chk", chk_cnt, 16'd0);

        // in_en toggling: 7 enabled samples to lock.
        send(1'b1, 1'b1, $urandom);
        send(1'b1, 1'b0, 32'd0);
        send(1'b0, 1'b0, $urandom);
        send(1'b1, 1'b0, 32'd1);
        send(1'b0, 1'b0, $urandom);
        send(1'b1, 1'b0, 32'd1);
        g2 = 32'd0; g1 = 32'd1; g0 = 32'd1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, $urandom);
            send(1'b1, 1'b0, gen_next());
        end
        check("toggle_lock", locked, 1'b1);

        // Randomised stream with corruption, gaps and rare clears.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) == 0) begin
                send(1'b1, 1'b1, $urandom);
            end else if ($urandom_range(9) < 2) begin
                send(1'b0, 1'b0, $urandom);
            end else begin
                w = gen_next();
                if ($urandom_range(99) < 8) w = w ^ ($urandom | 32'd1);
                send(1'b1, 1'b0, w);
            end
        end

        // Repeated LOCK mismatches: CNT_W=4 error counter must stick at 15.
        restart();
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 30 && !locked; k++) send(1'b1, 1'b0, gen_next());
            check("relock_bound", locked, 1'b1);
            w = gen_next();
            send(1'b1, 1'b0, w ^ 32'h8000_0001);
            check("sat_mis4", mis4, 1'b1);
        end
        check("err_cnt4_sat", err_cnt4, 4'd15);

        // Asynchronous reset mid-cycle.
        rst = 1'b1;
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_chk", chk_cnt, 16'd0);
        check("arst_errc", err_cnt, 16'd0);
        check("arst_errc4", err_cnt4, 4'd0);
        check("arst_bw", bad_word, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        restart();
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, gen_next());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
